// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: drives a 16-bit convert-then-read SPI ADC and emits one
// valid pulse per completed sample. Starts come from a periodic tick while
// enabled or from a trigger pulse; starts that land while busy set overrun.
module adc_spi_sampler #(
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned CONV_CYCLES   = 8,
  parameter int unsigned SAMPLE_PERIOD = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        trigger,
  input  logic        clear_overrun,
  input  logic        miso,
  output logic        cs_n,
  output logic        sclk,
  output logic        adc_data_valid,
  output logic [15:0] adc_data_value,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned ConvW = $clog2(CONV_CYCLES + 1);
  localparam int unsigned PerW  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [ConvW-1:0] ConvLast = ConvW'(CONV_CYCLES - 1);
  localparam logic [PerW-1:0]  PerLast  = PerW'(SAMPLE_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StConv, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [ConvW-1:0] conv_q, conv_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [3:0]       bit_q, bit_d;
  logic [15:0]      shreg_q, shreg_d;
  logic [15:0]      data_q, data_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic [PerW-1:0]  per_q;
  logic             tick;
  logic             start_req;

  assign tick      = enable && (per_q == PerLast);
  assign start_req = tick || trigger;

  // Period counter: free-runs while enabled, parked at zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_q <= '0;
    end else if (!enable || tick) begin
      per_q <= '0;
    end else begin
      per_q <= per_q + 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      conv_q    <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      conv_q    <= conv_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state: sequence CONV wait, 16 SCLK periods, then a one-cycle DONE.
  always_comb begin
    state_d = state_q;
    conv_d  = conv_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          state_d = StConv;
          cs_n_d  = 1'b0;
          conv_d  = ConvLast;
        end
      end
      StConv: begin
        if (conv_q == '0) begin
          state_d = StShift;
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          conv_d = conv_q - 1'b1;
        end
      end
      StShift: begin
        if (div_q == DivLast) begin
          div_d = '0;
          if (!sclk_q) begin
            // Rising SCLK edge: capture, MSB arrives first.
            sclk_d  = 1'b1;
            shreg_d = {shreg_q[14:0], miso};
          end else if (bit_q == 4'd15) begin
            state_d = StDone;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A dropped request beats a simultaneous clear.
    overrun_d = overrun_q;
    if (start_req && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end
  end

  assign cs_n           = cs_n_q;
  assign sclk           = sclk_q;
  assign adc_data_valid = valid_q;
  assign adc_data_value = data_q;
  assign busy           = (state_q != StIdle);
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench for adc_spi_sampler: ADC behavioural model plus an expected-sample
// queue checked on every valid pulse.
module tb_adc_spi_sampler;

  localparam int unsigned ClkDiv  = 2;
  localparam int unsigned ConvCyc = 4;
  localparam int unsigned Period  = 100;
  localparam int          Lat     = ConvCyc + 32 * ClkDiv + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        trigger = 1'b0;
  logic        clear_overrun = 1'b0;
  logic        miso = 1'b0;
  logic        cs_n, sclk, adc_data_valid, busy, overrun;
  logic [15:0] adc_data_value;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int valid_count = 0;
  int sclk_rises = 0;
  int csn_low = 0;
  int cs_falls = 0;
  int vcyc[$];
  logic [15:0] exp_q[$];
  logic [15:0] model_q[$];
  logic [15:0] word = '0;
  int          idx = 0;

  adc_spi_sampler #(
    .CLK_DIV      (ClkDiv),
    .CONV_CYCLES  (ConvCyc),
    .SAMPLE_PERIOD(Period)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .trigger       (trigger),
    .clear_overrun (clear_overrun),
    .miso          (miso),
    .cs_n          (cs_n),
    .sclk          (sclk),
    .adc_data_valid(adc_data_valid),
    .adc_data_value(adc_data_value),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // ADC model: new word on cs_n fall, next bit after each SCLK fall.
  always @(negedge cs_n) begin
    cs_falls++;
    word = (model_q.size() > 0) ? model_q.pop_front() : 16'h0000;
    idx  = 15;
    miso = word[15];
  end

  always @(negedge sclk) begin
    if (idx > 0) begin
      idx--;
      miso = word[idx];
    end
  end

  always @(posedge sclk) sclk_rises++;

  always @(negedge clk) if (cs_n === 1'b0) csn_low++;

  // Scoreboard: every valid pulse must match the oldest expected sample.
  always @(negedge clk) begin
    if (adc_data_valid === 1'b1) begin
      logic [15:0] e;
      valid_count++;
      vcyc.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: got value=%h, required no pulse", adc_data_value);
      end else begin
        e = exp_q.pop_front();
        if (adc_data_value !== e) begin
          bad++;
          $display("FAIL sample_value: got %h, required %h", adc_data_value, e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit seen, output int at);
    seen = 1'b0;
    at   = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (adc_data_valid === 1'b1) begin
        seen = 1'b1;
        at   = cyc;
        break;
      end
    end
    step(1);
  endtask

  task automatic clear_stats();
    valid_count = 0;
    sclk_rises  = 0;
    csn_low     = 0;
    cs_falls    = 0;
    vcyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    total += 6;
    if (cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n: got %b, required 1", cs_n); end
    if (sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk: got %b, required 0", sclk); end
    if (adc_data_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b, required 0", adc_data_valid);
    end
    if (adc_data_value !== 16'h0) begin
      bad++; $display("FAIL reset_value: got %h, required 0000", adc_data_value);
    end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (overrun !== 1'b0) begin
      bad++; $display("FAIL reset_overrun: got %b, required 0", overrun);
    end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_single();
    bit seen;
    int at, t0;
    clear_stats();
    model_q.push_back(16'hA5C3);
    exp_q.push_back(16'hA5C3);
    trigger = 1'b1;
    t0 = cyc;
    step(1);
    trigger = 1'b0;
    total += 2;
    if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b, required 1", busy); end
    if (overrun !== 1'b0) begin
      bad++; $display("FAIL single_no_overrun: got %b, required 0", overrun);
    end
    wait_valid(200, seen, at);
    total++;
    if (!seen || at - t0 != Lat) begin
      bad++; $display("FAIL single_latency: got %0d (seen=%0d), required %0d", at - t0, seen, Lat);
    end
    step(5);
    total += 5;
    if (sclk_rises != 16) begin
      bad++; $display("FAIL single_sclk_edges: got %0d, required 16", sclk_rises);
    end
    if (csn_low != Lat - 1) begin
      bad++; $display("FAIL single_cs_low: got %0d, required %0d", csn_low, Lat - 1);
    end
    if (adc_data_value !== 16'hA5C3) begin
      bad++; $display("FAIL single_hold: got %h, required a5c3", adc_data_value);
    end
    if (adc_data_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL single_idle: got valid=%b busy=%b, required 0 0", adc_data_valid, busy);
    end
    if (valid_count != 1) begin
      bad++; $display("FAIL single_pulses: got %0d, required 1", valid_count);
    end
  endtask

  task automatic test_periodic();
    int e;
    clear_stats();
    model_q.push_back(16'h0001); model_q.push_back(16'h8000); model_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0001);   exp_q.push_back(16'h8000);   exp_q.push_back(16'hFFFF);
    enable = 1'b1;
    e = cyc;
    step(350);
    enable = 1'b0;
    step(300);
    total += 3;
    if (vcyc.size() != 3 || cs_falls != 3) begin
      bad++; $display("FAIL periodic_count: got pulses=%0d starts=%0d, required 3 3",
                      vcyc.size(), cs_falls);
    end else begin
      if (vcyc[0] - e != int'(Period) - 1 + Lat) begin
        bad++; $display("FAIL periodic_first: got %0d, required %0d", vcyc[0] - e,
                        int'(Period) - 1 + Lat);
      end
      if (vcyc[1] - vcyc[0] != int'(Period) || vcyc[2] - vcyc[1] != int'(Period)) begin
        bad++; $display("FAIL periodic_spacing: got %0d %0d, required %0d", vcyc[1] - vcyc[0],
                        vcyc[2] - vcyc[1], Period);
      end
    end
  endtask

  task automatic test_overrun();
    bit seen;
    int at, t0;
    clear_stats();
    model_q.push_back(16'h3C5A); exp_q.push_back(16'h3C5A);
    trigger = 1'b1;
    t0 = cyc;
    step(1);
    trigger = 1'b0;
    step(9);
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b, required 1", overrun); end
    wait_valid(200, seen, at);
    total++;
    if (!seen || at - t0 != Lat) begin
      bad++; $display("FAIL overrun_inflight: got %0d (seen=%0d), required %0d", at - t0, seen, Lat);
    end
    step(2);
    clear_overrun = 1'b1;
    step(1);
    clear_overrun = 1'b0;
    total++;
    if (overrun !== 1'b0) begin
      bad++; $display("FAIL overrun_clear: got %b, required 0", overrun);
    end
    model_q.push_back(16'h0F0F); exp_q.push_back(16'h0F0F);
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    step(9);
    trigger = 1'b1;
    clear_overrun = 1'b1;
    step(1);
    trigger = 1'b0;
    clear_overrun = 1'b0;
    total++;
    if (overrun !== 1'b1) begin
      bad++; $display("FAIL overrun_set_wins: got %b, required 1", overrun);
    end
    wait_valid(200, seen, at);
    total++;
    if (!seen || valid_count != 2) begin
      bad++; $display("FAIL overrun_pulses: got %0d, required 2", valid_count);
    end
    clear_overrun = 1'b1;
    step(1);
    clear_overrun = 1'b0;
  endtask

  task automatic test_same_cycle();
    bit seen;
    int at, e;
    clear_stats();
    model_q.push_back(16'h1357); exp_q.push_back(16'h1357);
    enable = 1'b1;
    e = cyc;
    step(int'(Period) - 1);
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    enable = 1'b0;
    wait_valid(200, seen, at);
    total++;
    if (!seen || at - e != int'(Period) - 1 + Lat) begin
      bad++; $display("FAIL same_cycle_latency: got %0d (seen=%0d), required %0d", at - e, seen,
                      int'(Period) - 1 + Lat);
    end
    step(150);
    total++;
    if (valid_count != 1 || cs_falls != 1 || overrun !== 1'b0) begin
      bad++; $display("FAIL same_cycle_single: got pulses=%0d starts=%0d overrun=%b, required 1 1 0",
                      valid_count, cs_falls, overrun);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int at, n;
    clear_stats();
    model_q.push_back(16'h1234);
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    n = 0;
    while (sclk_rises < 7 && n < 200) begin
      step(1);
      n++;
    end
    total++;
    if (sclk_rises != 7) begin
      bad++; $display("FAIL reset_mid_reach: got %0d edges, required 7", sclk_rises);
    end
    step(2);
    #2 rst = 1'b1;
    #1;
    total++;
    if (cs_n !== 1'b1 || sclk !== 1'b0 || adc_data_value !== 16'h0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_outputs: got cs_n=%b sclk=%b value=%h busy=%b, required 1 0 0000 0",
                      cs_n, sclk, adc_data_value, busy);
    end
    step(3);
    rst = 1'b0;
    step(2);
    total++;
    if (valid_count != 0) begin
      bad++; $display("FAIL reset_mid_no_pulse: got %0d, required 0", valid_count);
    end
    model_q.push_back(16'h5AA5); exp_q.push_back(16'h5AA5);
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    wait_valid(200, seen, at);
    total++;
    if (!seen || adc_data_value !== 16'h5AA5) begin
      bad++; $display("FAIL reset_mid_recover: got %h (seen=%0d), required 5aa5", adc_data_value, seen);
    end
  endtask

  task automatic test_enable_drop();
    bit seen;
    int at, e;
    clear_stats();
    model_q.push_back(16'hC001); exp_q.push_back(16'hC001);
    enable = 1'b1;
    e = cyc;
    step(int'(Period) + 2);
    enable = 1'b0;
    total++;
    if (busy !== 1'b1 || cs_n !== 1'b0) begin
      bad++; $display("FAIL enable_drop_in_conv: got busy=%b cs_n=%b, required 1 0", busy, cs_n);
    end
    wait_valid(200, seen, at);
    total++;
    if (!seen || at - e != int'(Period) - 1 + Lat) begin
      bad++; $display("FAIL enable_drop_latency: got %0d (seen=%0d), required %0d", at - e, seen,
                      int'(Period) - 1 + Lat);
    end
    step(300);
    total++;
    if (valid_count != 1 || cs_falls != 1) begin
      bad++; $display("FAIL enable_drop_no_restart: got pulses=%0d starts=%0d, required 1 1",
                      valid_count, cs_falls);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_periodic();
    test_overrun();
    test_same_cycle();
    test_reset_mid();
    test_enable_drop();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
